regfile_write_port: RTL and testbench
=====================================

// Module: regfile_write_port
// PURPOSE
// - Write side of the 32x64 register file: takes write-back requests (rd, data) from the pipeline,
//   buffers them, and drives the file's one-hot Dselect and shared dbus, one register per cycle.
// - X31 is the hardwired zero register. Writes to it are accepted and discarded; it never forwards.
// - Supplies read-after-write forwarding for the A/B read addresses while writes are still pending.
// PARAMETERS
// - XLEN      64  data width of dbus and wb_data
// - NREGS     32  register count; also the Dselect width
// - DEPTH     2   pending-write buffer entries; must be a power of two, 2 or more
// - DROP_W    8   width of the saturating zero-register drop counter
// PORTS
// - clk        in   1      clock; all state updates on posedge clk
// - rst_n      in   1      asynchronous active-low reset
// - wb_valid   in   1      write request valid
// - wb_ready   out  1      buffer can accept; a transfer occurs when wb_valid && wb_ready
// - wb_rd      in   5      destination register number
// - wb_data    in   XLEN   write data
// - wr_hold    in   1      1 = do not issue writes to the file this cycle (buffer keeps filling)
// - Dselect    out  NREGS  one-hot write strobe to the file; registered
// - dbus       out  XLEN   write data to the file; registered
// - aaddr      in   5      read address, port A
// - baddr      in   5      read address, port B
// - a_fwd_hit  out  1      A address matches a pending or in-flight write
// - a_fwd_data out  XLEN   youngest matching data for A; 0 when no hit
// - b_fwd_hit  out  1      same as a_fwd_hit, for port B
// - b_fwd_data out  XLEN   same as a_fwd_data, for port B
// - pending    out  2      buffer occupancy, 0..DEPTH
// - zero_drops out  DROP_W count of discarded X31 writes; saturates at all-ones
// BEHAVIOUR
// - Reset while rst_n=0, asynchronous: Dselect=0, dbus=0, pending=0, zero_drops=0, buffer empty.
//   All pending writes are lost and none is issued after release. wb_ready=1 once rst_n=1.
// - wb_ready = (pending < DEPTH). It is combinational from occupancy, not from this cycle's pop,
//   so there is no push-through when the buffer is full.
// - Accept with wb_rd==31: the request is not enqueued and zero_drops increments, saturating.
// - Accept with wb_rd!=31: {rd,data} goes to the tail. Occupancy rises by one unless a pop happens
//   in the same edge; push and pop together leave occupancy unchanged.
// - Issue at each posedge:
//   - If pending>0 and wr_hold=0: Dselect <= 1<<head.rd, dbus <= head.data, and the head is popped.
//   - Otherwise Dselect <= 0 and dbus holds its last value.
// - Latency: a request accepted at edge N drives Dselect from edge N+1 to edge N+2 when the buffer
//   was empty and wr_hold=0. The file captures it on the negedge inside that window.
// - Throughput: one write per cycle. With wr_hold=0, streaming keeps occupancy at 1 or less, so
//   wb_ready stays 1.
// - Dselect is always one-hot or zero, never multi-hot.
// - Forwarding is combinational.
//   - Candidates: all valid buffer entries plus the output stage while Dselect!=0.
//   - Priority, youngest first: buffer tail ... buffer head, then the output stage.
//   - Address 31 never hits. A same-cycle incoming wb_* request is not a candidate.
// - wr_hold asserted mid-stream: Dselect goes 0 at the next edge and buffer order is preserved.
//   Release resumes issue from the head.
// STRUCTURE
// - Shared header regfile_defs.vh holds: XLEN, NREGS, REG_AW=5, ZERO_REG=5'd31, and the
//   wb entry field layout {rd[4:0], data[XLEN-1:0]}. The existing register modules use it too.
// - Sub-module wb_fifo: DEPTH-entry synchronous FIFO.
//   - Ports: push, pop, din, dout, count, plus a flat entry/valid view for the forwarding compare.
// - Top level holds: zero-register filter, drop counter, output stage, forwarding priority mux.
// TESTING
// - Reset: hold rst_n=0 -> Dselect=0, dbus=0, pending=0, zero_drops=0; after release wb_ready=1.
// - Single write: rd=5, data=64'hDEADBEEF_00000005 at edge N -> Dselect=32'h0000_0020 with that dbus
//   for one cycle; Dselect=0 after edge N+2.
// - Zero register: writes rd=31 x3 -> Dselect stays 0, zero_drops=3; aaddr=31 -> a_fwd_hit=0.
//   A forced 2^DROP_W+5 drops -> zero_drops=8'hFF.
// - Hold and forward:
//   - With wr_hold=1, push rd=3 A=64'h1111 then rd=3 B=64'h2222 -> pending=2, wb_ready=0.
//   - aaddr=3 -> a_fwd_hit=1, a_fwd_data=64'h2222. baddr=4 -> b_fwd_hit=0, b_fwd_data=0.
//   - Release wr_hold -> Dselect=32'h8 with dbus=A, then Dselect=32'h8 with dbus=B.
// - Streaming: wr_hold=0, rd=1..4 on consecutive cycles -> Dselect=2,4,8,16 on consecutive cycles;
//   wb_ready never drops; pending never exceeds 1.
// - Reset mid-operation: pending=2 with wr_hold=1, pulse rst_n low between edges -> Dselect=0
//   immediately, pending=0; no Dselect activity after release.

Source files
------------

// File: rtl/regfile_write_port_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_port_pkg
// Brief  : Shared register-file constants and the zero-register helper.
// Rev    : 1.0
// ============================================================================
package regfile_write_port_pkg;

    localparam int RF_XLEN  = 64;
    localparam int RF_NREGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] rd);
        return (rd == ZERO_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_port_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_port_wb_fifo
// Brief  : DEPTH-entry synchronous FIFO with an age-ordered flat entry view.
// Rev    : 1.0
// ============================================================================
module regfile_write_port_wb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH*W-1:0]           view_data,
    output logic [DEPTH-1:0]             view_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = din;
            tail_d        = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;

    // Slot i of the view is the i-th oldest entry; pointer wrap is free since DEPTH is 2^AW.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_view
            logic [AW-1:0] idx;
            assign idx                   = head_q + AW'(i);
            assign view_data[i*W +: W]   = mem_q[idx];
            assign view_valid[i]         = (CW'(i) < count_q);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module : regfile_write_port
// Brief  : Buffered write side of the register file with zero-register filter
//          and read-after-write forwarding for the A/B read ports.
// Rev    : 1.0
// ============================================================================
module regfile_write_port
    import regfile_write_port_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int DEPTH  = 2,
    parameter int DROP_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [REG_AW-1:0]            wb_rd,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         wr_hold,
    output logic [NREGS-1:0]             Dselect,
    output logic [XLEN-1:0]              dbus,
    input  logic [REG_AW-1:0]            aaddr,
    input  logic [REG_AW-1:0]            baddr,
    output logic                         a_fwd_hit,
    output logic [XLEN-1:0]              a_fwd_data,
    output logic                         b_fwd_hit,
    output logic [XLEN-1:0]              b_fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic [DROP_W-1:0]            zero_drops
);

    localparam int W  = REG_AW + XLEN;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]        fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic [DEPTH*W-1:0]  fifo_view;
    logic [DEPTH-1:0]    fifo_view_valid;
    logic                accept, push, pop;

    logic [NREGS-1:0]    dselect_q, dselect_d;
    logic [XLEN-1:0]     dbus_q, dbus_d;
    logic [DROP_W-1:0]   drops_q, drops_d;

    assign wb_ready = (fifo_count < CW'(DEPTH));
    assign accept   = wb_valid && wb_ready;
    assign push     = accept && !is_zero_reg(wb_rd);
    assign pop      = (|fifo_count) && !wr_hold;

    regfile_write_port_wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .din        ({wb_rd, wb_data}),
        .dout       (fifo_dout),
        .count      (fifo_count),
        .view_data  (fifo_view),
        .view_valid (fifo_view_valid)
    );

    always_comb begin
        dselect_d = '0;
        dbus_d    = dbus_q;
        drops_d   = drops_q;
        if (pop) begin
            dselect_d = {{(NREGS-1){1'b0}}, 1'b1} << fifo_dout[W-1 -: REG_AW];
            dbus_d    = fifo_dout[XLEN-1:0];
        end
        if (accept && is_zero_reg(wb_rd) && (drops_q != '1)) begin
            drops_d = drops_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dselect_q <= '0;
            dbus_q    <= '0;
            drops_q   <= '0;
        end else begin
            dselect_q <= dselect_d;
            dbus_q    <= dbus_d;
            drops_q   <= drops_d;
        end
    end

    assign Dselect    = dselect_q;
    assign dbus       = dbus_q;
    assign pending    = fifo_count;
    assign zero_drops = drops_q;

    logic [REG_AW-1:0]       fwd_addr [2];
    logic [1:0]              fwd_hit;
    logic [1:0][XLEN-1:0]    fwd_data;

    assign fwd_addr[0] = aaddr;
    assign fwd_addr[1] = baddr;

    // Scan oldest to youngest so the youngest match wins: output stage, then head..tail.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_fwd
            logic            hit;
            logic [XLEN-1:0] data;
            always_comb begin
                hit  = dselect_q[fwd_addr[p]];
                data = hit ? dbus_q : '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo_view_valid[i] &&
                        (fifo_view[i*W + XLEN +: REG_AW] == fwd_addr[p])) begin
                        hit  = 1'b1;
                        data = fifo_view[i*W +: XLEN];
                    end
                end
                if (is_zero_reg(fwd_addr[p])) begin
                    hit  = 1'b0;
                    data = '0;
                end
            end
            assign fwd_hit[p]  = hit;
            assign fwd_data[p] = data;
        end
    endgenerate

    assign a_fwd_hit  = fwd_hit[0];
    assign a_fwd_data = fwd_data[0];
    assign b_fwd_hit  = fwd_hit[1];
    assign b_fwd_data = fwd_data[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_write_port
// Brief  : Directed plus randomized bench for regfile_write_port against a
//          queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_regfile_write_port;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wr_hold;
    logic [31:0] Dselect;
    logic [63:0] dbus;
    logic [4:0]  aaddr, baddr;
    logic        a_fwd_hit, b_fwd_hit;
    logic [63:0] a_fwd_data, b_fwd_data;
    logic [1:0]  pending;
    logic [7:0]  zero_drops;

    always #5 clk = ~clk;

    regfile_write_port #(
        .XLEN   (64),
        .NREGS  (32),
        .DEPTH  (DEPTH),
        .DROP_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wr_hold    (wr_hold),
        .Dselect    (Dselect),
        .dbus       (dbus),
        .aaddr      (aaddr),
        .baddr      (baddr),
        .a_fwd_hit  (a_fwd_hit),
        .a_fwd_data (a_fwd_data),
        .b_fwd_hit  (b_fwd_hit),
        .b_fwd_data (b_fwd_data),
        .pending    (pending),
        .zero_drops (zero_drops)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_out_valid;
    logic [4:0]  m_out_rd;
    logic [63:0] m_dbus;
    int          m_drops;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_out_valid = 1'b0;
        m_out_rd    = '0;
        m_dbus      = '0;
        m_drops     = 0;
    endfunction

    function automatic void model_fwd(input logic [4:0] addr, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (addr == 5'd31) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == addr) begin
                hit = 1'b1;
                d   = mq[i].data;
                return;
            end
        end
        if (m_out_valid && m_out_rd == addr) begin
            hit = 1'b1;
            d   = m_dbus;
        end
    endfunction

    task automatic check_all();
        logic        eh;
        logic [63:0] ed;
        logic [31:0] edsel;
        edsel = m_out_valid ? (32'd1 << m_out_rd) : 32'd0;
        chk("wb_ready",   wb_ready,   (mq.size() < DEPTH));
        chk("pending",    pending,    mq.size());
        chk("Dselect",    Dselect,    edsel);
        chk("dbus",       dbus,       m_dbus);
        chk("zero_drops", zero_drops, m_drops);
        chk("onehot0",    $onehot0(Dselect), 1'b1);
        model_fwd(aaddr, eh, ed);
        chk("a_fwd_hit",  a_fwd_hit,  eh);
        chk("a_fwd_data", a_fwd_data, ed);
        model_fwd(baddr, eh, ed);
        chk("b_fwd_hit",  b_fwd_hit,  eh);
        chk("b_fwd_data", b_fwd_data, ed);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at the edge.
    task automatic cycle(input logic v, input logic [4:0] rd, input logic [63:0] d,
                         input logic h, input logic [4:0] aa, input logic [4:0] ba);
        bit acc;
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
        wr_hold  = h;
        aaddr    = aa;
        baddr    = ba;
        @(negedge clk);
        check_all();
        acc = v && (mq.size() < DEPTH);
        if (mq.size() > 0 && !h) begin
            m_out_valid = 1'b1;
            m_out_rd    = mq[0].rd;
            m_dbus      = mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_out_valid = 1'b0;
        end
        if (acc) begin
            if (rd == 5'd31) begin
                if (m_drops < 255) m_drops++;
            end else begin
                mq.push_back('{rd: rd, data: d});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic h);
        cycle(1'b0, 5'd0, 64'd0, h, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        wr_hold = 1'b0; aaddr = '0; baddr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_Dselect", Dselect, 32'd0);
        chk("rst_dbus",    dbus,    64'd0);
        chk("rst_pending", pending, 2'd0);
        chk("rst_drops",   zero_drops, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready",   wb_ready, 1'b1);

        // Single write
        cycle(1'b1, 5'd5, 64'hDEADBEEF_00000005, 1'b0, 5'd5, 5'd6);
        idle(1'b0);
        chk("single_Dselect", Dselect, 32'h0000_0020);
        chk("single_dbus",    dbus,    64'hDEADBEEF_00000005);
        idle(1'b0);
        chk("single_Dselect_off", Dselect, 32'd0);

        // Zero register
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd31, 64'hABCD + i, 1'b0, 5'd31, 5'd31);
        idle(1'b0);
        chk("zero_drops3", zero_drops, 8'd3);
        chk("zero_Dselect", Dselect, 32'd0);
        aaddr = 5'd31; #1;
        chk("zero_a_hit", a_fwd_hit, 1'b0);

        // Hold and forward
        cycle(1'b1, 5'd3, 64'h1111, 1'b1, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 64'h2222, 1'b1, 5'd0, 5'd0);
        wr_hold = 1'b1; wb_valid = 1'b0; aaddr = 5'd3; baddr = 5'd4;
        #1;
        chk("hold_pending", pending, 2'd2);
        chk("hold_ready",   wb_ready, 1'b0);
        chk("hold_a_hit",   a_fwd_hit, 1'b1);
        chk("hold_a_data",  a_fwd_data, 64'h2222);
        chk("hold_b_hit",   b_fwd_hit, 1'b0);
        chk("hold_b_data",  b_fwd_data, 64'h0);
        idle(1'b0);
        chk("rel_Dselect0", Dselect, 32'h8);
        chk("rel_dbus0",    dbus,    64'h1111);
        idle(1'b0);
        chk("rel_Dselect1", Dselect, 32'h8);
        chk("rel_dbus1",    dbus,    64'h2222);
        idle(1'b0);

        // Streaming
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 5'(i), 64'h100 + i, 1'b0, 5'(i), 5'(i - 1));
            chk("stream_ready", wb_ready, 1'b1);
            chk("stream_pend_le1", (pending <= 2'd1), 1'b1);
            if (i > 1) chk("stream_Dselect", Dselect, 32'd1 << (i - 1));
        end
        idle(1'b0);
        chk("stream_Dselect_last", Dselect, 32'd16);
        idle(1'b0);

        // Saturating drop counter
        for (int i = 0; i < 256 + 5; i++) cycle(1'b1, 5'd31, 64'(i), 1'b0, 5'd31, 5'd0);
        chk("drops_sat", zero_drops, 8'hFF);

        // Reset mid-operation with writes pending and one in flight
        cycle(1'b1, 5'd7, 64'h7777, 1'b1, 5'd7, 5'd8);
        cycle(1'b1, 5'd8, 64'h8888, 1'b1, 5'd7, 5'd8);
        idle(1'b0);
        chk("pre_rst_Dselect", Dselect, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_Dselect", Dselect, 32'd0);
        chk("mid_rst_pending", pending, 2'd0);
        chk("mid_rst_drops",   zero_drops, 8'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("post_rst_quiet", Dselect, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), rd, {$urandom, $urandom},
                  1'($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 8)), 5'($urandom_range(0, 8) == 8 ? 31 : $urandom_range(0, 7)));
        end
        for (int n = 0; n < 4; n++) idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
